// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: shared widths, FSM state encoding, ALU select codes and opcode map
package cpu_control_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [OP_W-1:0] OP_ADD_A = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV_AB = 4'h1;
  localparam logic [OP_W-1:0] OP_IN_A  = 4'h2;
  localparam logic [OP_W-1:0] OP_MOV_AI = 4'h3;
  localparam logic [OP_W-1:0] OP_MOV_BA = 4'h4;
  localparam logic [OP_W-1:0] OP_ADD_B = 4'h5;
  localparam logic [OP_W-1:0] OP_IN_B  = 4'h6;
  localparam logic [OP_W-1:0] OP_MOV_BI = 4'h7;
  localparam logic [OP_W-1:0] OP_OUT_B = 4'h9;
  localparam logic [OP_W-1:0] OP_OUT_I = 4'hB;
  localparam logic [OP_W-1:0] OP_JNC   = 4'hE;
  localparam logic [OP_W-1:0] OP_JMP   = 4'hF;
endpackage

// File: rtl/cpu_control_decode.sv
// cpu_control_decode: opcode+carry -> sel, load_a/b/out, pc_inc/pc_load, imm_zero, is_add (combinational)
module cpu_control_decode
  import cpu_control_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            carry,
  output logic [1:0]      sel,
  output logic            load_a,
  output logic            load_b,
  output logic            load_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            imm_zero,
  output logic            is_add
);
  always_comb begin
    sel = SEL_A;
    load_a = 1'b0;
    load_b = 1'b0;
    load_out = 1'b0;
    pc_inc = 1'b1;
    pc_load = 1'b0;
    imm_zero = 1'b0;
    is_add = 1'b0;
    case (op)
      OP_ADD_A: begin
        is_add = 1'b1;
        load_a = 1'b1;
      end
      OP_ADD_B: begin
        is_add = 1'b1;
        sel = SEL_B;
        load_b = 1'b1;
      end
      OP_MOV_AI: begin
        sel = SEL_ZERO;
        load_a = 1'b1;
      end
      OP_MOV_BI: begin
        sel = SEL_ZERO;
        load_b = 1'b1;
      end
      OP_MOV_AB: begin
        sel = SEL_B;
        load_a = 1'b1;
        imm_zero = 1'b1;
      end
      OP_MOV_BA: begin
        load_b = 1'b1;
        imm_zero = 1'b1;
      end
      OP_IN_A: begin
        sel = SEL_IN;
        load_a = 1'b1;
        imm_zero = 1'b1;
      end
      OP_IN_B: begin
        sel = SEL_IN;
        load_b = 1'b1;
        imm_zero = 1'b1;
      end
      OP_OUT_B: begin
        sel = SEL_B;
        load_out = 1'b1;
        imm_zero = 1'b1;
      end
      OP_OUT_I: begin
        sel = SEL_ZERO;
        load_out = 1'b1;
      end
      OP_JMP: begin
        pc_inc = 1'b0;
        pc_load = 1'b1;
      end
      OP_JNC: begin
        pc_inc = carry;
        pc_load = ~carry;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: fetch/exec FSM (clk, clr, run, rom_req/ack/data) driving imm, sel, load_a/b/out, pc_inc/pc_load, carry, busy
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int DATA_W = cpu_control_pkg::DATA_W,
  parameter int OP_W = cpu_control_pkg::OP_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   run,
  output logic                   rom_req,
  input  logic                   rom_ack,
  input  logic [OP_W+DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0]      imm,
  output logic [1:0]             sel,
  input  logic                   alu_carry,
  output logic                   load_a,
  output logic                   load_b,
  output logic                   load_out,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   carry,
  output logic                   busy
);
  state_t state;
  logic [OP_W+DATA_W-1:0] ir;
  logic ex;
  logic [1:0] d_sel;
  logic d_la, d_lb, d_lo, d_inc, d_ld, imm_zero, is_add;
  cpu_control_decode u_decode (
    .op      (ir[OP_W+DATA_W-1:DATA_W]),
    .carry   (carry),
    .sel     (d_sel),
    .load_a  (d_la),
    .load_b  (d_lb),
    .load_out(d_lo),
    .pc_inc  (d_inc),
    .pc_load (d_ld),
    .imm_zero(imm_zero),
    .is_add  (is_add)
  );
  assign ex = state == EXEC;
  assign rom_req = state == FETCH;
  assign busy = state != IDLE;
  assign sel = ex ? d_sel : 2'b00;
  assign imm = ex && !imm_zero ? ir[DATA_W-1:0] : '0;
  assign load_a = ex & d_la;
  assign load_b = ex & d_lb;
  assign load_out = ex & d_lo;
  assign pc_inc = ex & d_inc;
  assign pc_load = ex & d_ld;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      ir <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= run ? FETCH : IDLE;
        FETCH: if (rom_ack) begin
          ir <= rom_data;
          state <= EXEC;
        end
        EXEC: begin
          carry <= is_add & alu_carry;
          state <= run ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: scoreboard bench for cpu_control
module tb_cpu_control;
  typedef struct {
    logic [1:0] sel;
    logic [3:0] imm;
    logic la, lb, lo, pi, pl, c, cs, ci;
  } exp_t;
  logic clk = 1'b0;
  logic clr, run, rom_ack, alu_carry;
  logic [7:0] rom_data;
  logic rom_req, load_a, load_b, load_out, pc_inc, pc_load, carry, busy;
  logic [3:0] imm;
  logic [1:0] sel;
  logic mon = 1'b0;
  logic mc = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t m_e;
  cpu_control dut (
    .clk(clk), .clr(clr), .run(run), .rom_req(rom_req), .rom_ack(rom_ack),
    .rom_data(rom_data), .imm(imm), .sel(sel), .alu_carry(alu_carry),
    .load_a(load_a), .load_b(load_b), .load_out(load_out), .pc_inc(pc_inc),
    .pc_load(pc_load), .carry(carry), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] ins, input logic c);
    exp_t e;
    e = '{sel: 2'd0, imm: ins[3:0], la: 1'b0, lb: 1'b0, lo: 1'b0, pi: 1'b1, pl: 1'b0, c: c, cs: 1'b1, ci: 1'b1};
    case (ins[7:4])
      4'h0: e.la = 1'b1;
      4'h5: begin e.sel = 2'd1; e.lb = 1'b1; end
      4'h3: begin e.sel = 2'd3; e.la = 1'b1; end
      4'h7: begin e.sel = 2'd3; e.lb = 1'b1; end
      4'h1: begin e.sel = 2'd1; e.la = 1'b1; e.imm = 4'h0; end
      4'h4: begin e.sel = 2'd0; e.lb = 1'b1; e.imm = 4'h0; end
      4'h2: begin e.sel = 2'd2; e.la = 1'b1; e.imm = 4'h0; end
      4'h6: begin e.sel = 2'd2; e.lb = 1'b1; e.imm = 4'h0; end
      4'h9: begin e.sel = 2'd1; e.lo = 1'b1; e.imm = 4'h0; end
      4'hB: begin e.sel = 2'd3; e.lo = 1'b1; end
      4'hF: begin e.pi = 1'b0; e.pl = 1'b1; e.cs = 1'b0; end
      4'hE: begin e.pi = c; e.pl = ~c; e.cs = 1'b0; end
      default: begin e.cs = 1'b0; e.ci = 1'b0; end
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    if (mon) begin
      if (busy && !rom_req) begin
        if (q.size() == 0) chk("unexpected_exec", q.size(), 1);
        else begin
          m_e = q.pop_front();
          chk("strobes", {load_a, load_b, load_out, pc_inc, pc_load}, {m_e.la, m_e.lb, m_e.lo, m_e.pi, m_e.pl});
          chk("carry_in_exec", carry, m_e.c);
          if (m_e.cs) chk("sel", sel, m_e.sel);
          if (m_e.ci) chk("imm", imm, m_e.imm);
        end
      end else chk("strobes_off", {load_a, load_b, load_out, pc_inc, pc_load}, 5'b0);
    end
  end
  task automatic do_instr(input logic [7:0] ins, input int dly, input logic ac, input logic drop);
    int n;
    n = 0;
    while (!rom_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", rom_req, 1);
    if (drop) run = 1'b0;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("req_hold", {rom_req, busy}, 2'b11);
    end
    rom_ack = 1'b1;
    rom_data = ins;
    alu_carry = ac;
    q.push_back(model(ins, mc));
    mc = (ins[7:4] == 4'h0 || ins[7:4] == 4'h5) ? ac : 1'b0;
    @(negedge clk);
    rom_ack = 1'b0;
    rom_data = 8'($urandom);
    chk("exec_req", {rom_req, busy}, 2'b01);
    @(negedge clk);
    chk("after_exec", {rom_req, busy}, run ? 2'b11 : 2'b00);
  endtask
  initial begin
    clr = 1'b1;
    run = 1'b0;
    rom_ack = 1'b0;
    rom_data = 8'h00;
    alu_carry = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, rom_req, carry}, 3'b000);
    chk("rst_imm_sel", {imm, sel}, 6'b0);
    chk("rst_strobes", {load_a, load_b, load_out, pc_inc, pc_load}, 5'b0);
    mon = 1'b1;
    clr = 1'b0;
    run = 1'b1;
    do_instr(8'h35, 0, 1'b0, 1'b0);
    do_instr(8'h97, 3, 1'b0, 1'b0);
    do_instr(8'h0F, 0, 1'b1, 1'b0);
    do_instr(8'h1E, 1, 1'b0, 1'b0);
    do_instr(8'h1E, 0, 1'b0, 1'b0);
    do_instr(8'hF3, 0, 1'b0, 1'b0);
    do_instr(8'h8A, 2, 1'b0, 1'b0);
    do_instr(8'h05, 0, 1'b1, 1'b0);
    do_instr(8'h54, 0, 1'b0, 1'b0);
    do_instr(8'h16, 0, 1'b1, 1'b0);
    do_instr(8'h27, 1, 1'b0, 1'b0);
    do_instr(8'h6F, 0, 1'b0, 1'b0);
    do_instr(8'h48, 0, 1'b0, 1'b0);
    do_instr(8'h7C, 0, 1'b0, 1'b0);
    do_instr(8'hB9, 0, 1'b0, 1'b0);
    do_instr(8'hC0, 0, 1'b0, 1'b0);
    do_instr(8'h0F, 1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("stopped", {busy, rom_req}, 2'b00);
    chk("carry_held", carry, mc);
    run = 1'b1;
    do_instr(8'h1E, 0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !rom_req; k++) @(negedge clk);
    chk("clr_req_seen", rom_req, 1);
    clr = 1'b1;
    rom_ack = 1'b1;
    rom_data = 8'h35;
    @(negedge clk);
    clr = 1'b0;
    rom_ack = 1'b0;
    run = 1'b0;
    mc = 1'b0;
    chk("clr_idle", {busy, rom_req, carry}, 3'b000);
    chk("clr_imm_sel", {imm, sel}, 6'b0);
    repeat (3) @(negedge clk);
    chk("clr_stay_idle", {busy, rom_req}, 2'b00);
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
